// File: rtl/run_sequencer_if.sv
// Load stream, dump stream and data-memory port between the run sequencer and its surroundings.
interface run_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       mem_sel;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  modport master (
    input  in_valid, in_data, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, mem_sel, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, mem_sel, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/run_sequencer.sv
// Run control ahead of the datapath: load image, hold START, run until DONE or timeout, dump results.
module run_sequencer #(
  parameter int unsigned LOAD_BASE    = 0,
  parameter int unsigned LOAD_LEN     = 64,
  parameter int unsigned DUMP_BASE    = 64,
  parameter int unsigned DUMP_LEN     = 32,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 65535
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   go,
  run_sequencer_if.master        bus,
  output logic                   START,
  input  logic                   DONE,
  output logic                   busy,
  output logic                   run_done,
  output logic                   timed_out,
  output logic [15:0]            run_cycles
);

  localparam int unsigned IDX_W  = 9;
  localparam int unsigned INIT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [7:0]        LOAD_BASE8 = 8'(LOAD_BASE);
  localparam logic [7:0]        DUMP_BASE8 = 8'(DUMP_BASE);
  localparam logic [IDX_W-1:0]  LOAD_LAST  = IDX_W'(LOAD_LEN - 1);
  localparam logic [IDX_W-1:0]  DUMP_LAST  = IDX_W'(DUMP_LEN - 1);
  localparam logic [INIT_W-1:0] INIT_LAST  = INIT_W'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_RUN,
    S_DUMP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [15:0]        run_cycles_d;
  logic               timed_out_d;
  logic               run_done_d;
  logic               first_run;
  logic               timeout_hit;

  // DONE is only honoured once a full RUN cycle has elapsed; the count includes the current cycle.
  assign first_run   = (run_cycles == 16'd0);
  assign timeout_hit = ({16'd0, run_cycles} + 32'd1) >= TIMEOUT;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      init_cnt_q <= '0;
      run_cycles <= 16'd0;
      timed_out  <= 1'b0;
      run_done   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      init_cnt_q <= init_cnt_d;
      run_cycles <= run_cycles_d;
      timed_out  <= timed_out_d;
      run_done   <= run_done_d;
      busy       <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    init_cnt_d    = init_cnt_q;
    run_cycles_d  = run_cycles;
    timed_out_d   = timed_out;
    run_done_d    = 1'b0;
    START         = 1'b1;
    bus.in_ready  = 1'b0;
    bus.mem_sel   = 1'b1;
    bus.mem_addr  = 8'd0;
    bus.mem_wdata = 8'd0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d      = S_LOAD;
          idx_d        = '0;
          timed_out_d  = 1'b0;
          run_cycles_d = 16'd0;
        end
      end

      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.mem_addr = LOAD_BASE8 + idx_q[7:0];
        if (bus.in_valid) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = bus.in_data;
          if (idx_q == LOAD_LAST) begin
            idx_d      = '0;
            init_cnt_d = '0;
            state_d    = S_INIT;
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end

      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          state_d    = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        START        = 1'b0;
        bus.mem_sel  = 1'b0;
        run_cycles_d = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
        if (DONE && !first_run) begin
          state_d = S_DUMP;
        end else if (timeout_hit) begin
          timed_out_d = 1'b1;
          state_d     = S_DUMP;
        end
      end

      S_DUMP: begin
        bus.mem_re    = 1'b1;
        bus.mem_addr  = DUMP_BASE8 + idx_q[7:0];
        bus.out_valid = 1'b1;
        bus.out_data  = bus.mem_rdata;
        if (bus.out_ready) begin
          if (idx_q == DUMP_LAST) begin
            idx_d      = '0;
            run_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: spec-level reference model checked every cycle plus hand-computed expectations.
module tb_run_sequencer;

  localparam int unsigned LB = 0;
  localparam int unsigned LL = 4;
  localparam int unsigned DB = 254;
  localparam int unsigned DL = 4;
  localparam int unsigned SC = 2;
  localparam int unsigned TO = 50;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_INIT = 2;
  localparam int M_RUN  = 3;
  localparam int M_DUMP = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic        go;
  logic        DONE;
  logic        START;
  logic        busy;
  logic        run_done;
  logic        timed_out;
  logic [15:0] run_cycles;

  run_sequencer_if bus();

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  logic chk_en = 1'b0;
  int   rd_pulses = 0;
  logic [7:0] wlog_a[$];
  logic [7:0] wlog_d[$];
  int         wlog_c[$];

  // Reference model state, in the specification's own terms
  int   m_mode = M_IDLE;
  int   m_cnt  = 0;
  int   m_rc   = 0;
  logic m_to   = 1'b0;
  logic m_rd   = 1'b0;

  logic [7:0] b1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] b2 [4] = '{8'hA2, 8'hA3, 8'h55, 8'h66};
  logic [7:0] got[4];

  always #5 CLK = ~CLK;

  run_sequencer #(
    .LOAD_BASE(LB), .LOAD_LEN(LL), .DUMP_BASE(DB), .DUMP_LEN(DL),
    .START_CYCLES(SC), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .reset(reset), .go(go), .bus(bus), .START(START), .DONE(DONE),
    .busy(busy), .run_done(run_done), .timed_out(timed_out), .run_cycles(run_cycles)
  );

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_sel && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  always @(posedge CLK) begin
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (!reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_rc = 0; m_to = 1'b0; m_rd = 1'b0;
    end else begin
      m_rd = 1'b0;
      case (m_mode)
        M_IDLE: if (go) begin m_mode = M_LOAD; m_cnt = 0; m_rc = 0; m_to = 1'b0; end
        M_LOAD: if (bus.in_valid) begin
          ref_mem[(LB + m_cnt) % 256] = bus.in_data;
          m_cnt++;
          if (m_cnt == LL) begin m_mode = M_INIT; m_cnt = 0; end
        end
        M_INIT: begin
          m_cnt++;
          if (m_cnt == SC) begin m_mode = M_RUN; m_cnt = 0; end
        end
        M_RUN: begin
          if (m_rc < 65535) m_rc++;
          if (DONE && m_rc > 1) m_mode = M_DUMP;
          else if (m_rc >= TO) begin m_to = 1'b1; m_mode = M_DUMP; end
        end
        M_DUMP: if (bus.out_ready) begin
          m_cnt++;
          if (m_cnt == DL) begin m_mode = M_IDLE; m_cnt = 0; m_rd = 1'b1; end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      cyc_n++;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cyc(1);
    pl_en = 1'b0;
  endtask

  task automatic wait_start_low(output int n);
    n = 0;
    while (START && n < 20) begin n++; cyc(1); end
  endtask

  int t0, n, w0, r0;

  initial begin
    reset = 1'b0; go = 1'b0; DONE = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b0;
    pl_en = 1'b0; pl_addr = 8'd0; pl_data = 8'd0;

    // Per-cycle comparison against the reference model, plus write/pulse monitors
    fork
      forever begin
        @(negedge CLK);
        if (chk_en) begin
          chk("START",      32'(START),          32'(m_mode != M_RUN));
          chk("mem_sel",    32'(bus.mem_sel),    32'(m_mode != M_RUN));
          chk("busy",       32'(busy),           32'(m_mode != M_IDLE));
          chk("in_ready",   32'(bus.in_ready),   32'(m_mode == M_LOAD));
          chk("mem_we",     32'(bus.mem_we),     32'(m_mode == M_LOAD && bus.in_valid));
          chk("mem_re",     32'(bus.mem_re),     32'(m_mode == M_DUMP));
          chk("out_valid",  32'(bus.out_valid),  32'(m_mode == M_DUMP));
          chk("run_cycles", 32'(run_cycles),     32'(m_rc));
          chk("timed_out",  32'(timed_out),      32'(m_to));
          chk("run_done",   32'(run_done),       32'(m_rd));
          if (m_mode == M_LOAD && bus.in_valid) begin
            chk("wr_addr",  32'(bus.mem_addr),   32'((LB + m_cnt) % 256));
            chk("wr_data",  32'(bus.mem_wdata),  32'(bus.in_data));
          end
          if (m_mode == M_DUMP) begin
            chk("rd_addr",  32'(bus.mem_addr),   32'((DB + m_cnt) % 256));
            chk("out_data", 32'(bus.out_data),   32'(ref_mem[(DB + m_cnt) % 256]));
          end
          if (bus.mem_sel && bus.mem_we) begin
            wlog_a.push_back(bus.mem_addr);
            wlog_d.push_back(bus.mem_wdata);
            wlog_c.push_back(cyc_n);
          end
          if (run_done) rd_pulses++;
        end
      end
    join_none

    @(posedge CLK); #1;
    chk_en = 1'b1;
    cyc(2);
    chk("rst_START",     32'(START),         32'd1);
    chk("rst_mem_sel",   32'(bus.mem_sel),   32'd1);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_re",    32'(bus.mem_re),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_run_cycles",32'(run_cycles),    32'd0);
    chk("rst_timed_out", 32'(timed_out),     32'd0);
    chk("rst_run_done",  32'(run_done),      32'd0);
    reset = 1'b1;
    preload(8'd254, 8'hA0);
    preload(8'd255, 8'hA1);

    // Run 1: basic run, gapless load, DONE 20 cycles after START falls, stray go mid-run
    t0 = cyc_n;
    go = 1'b1; cyc(1); go = 1'b0;
    w0 = wlog_a.size();
    for (int i = 0; i < 4; i++) begin bus.in_valid = 1'b1; bus.in_data = b1[i]; cyc(1); end
    bus.in_valid = 1'b0;
    chk("basic_mem0", 32'(mem[0]), 32'h11);
    chk("basic_mem1", 32'(mem[1]), 32'h22);
    chk("basic_mem2", 32'(mem[2]), 32'h33);
    chk("basic_mem3", 32'(mem[3]), 32'h44);
    chk("basic_wr_count", 32'(wlog_a.size() - w0), 32'd4);
    if (wlog_c.size() >= w0 + 4) chk("basic_wr_consecutive", 32'(wlog_c[w0 + 3] - wlog_c[w0]), 32'd3);
    wait_start_low(n);
    chk("basic_init_cycles", 32'(n), 32'd2);
    cyc(5); go = 1'b1; cyc(1); go = 1'b0; cyc(14);
    DONE = 1'b1; cyc(1); DONE = 1'b0;
    chk("basic_dump_entry", 32'(bus.out_valid), 32'd1);
    chk("basic_run_cycles", 32'(run_cycles),    32'd21);
    chk("basic_latency",    32'(cyc_n - t0),    32'd28);
    r0 = rd_pulses;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin got[i] = bus.out_data; cyc(1); end
    bus.out_ready = 1'b0;
    chk("basic_dump0", 32'(got[0]), 32'hA0);
    chk("basic_dump1", 32'(got[1]), 32'hA1);
    chk("basic_dump2", 32'(got[2]), 32'h11);
    chk("basic_dump3", 32'(got[3]), 32'h22);
    chk("basic_run_done", 32'(run_done), 32'd1);
    cyc(2);
    chk("basic_rd_pulses", 32'(rd_pulses - r0), 32'd1);

    // Run 2: gapped load, DONE already high in the first RUN cycle, stalled wrapping dump
    DONE = 1'b1;
    go = 1'b1; cyc(1); go = 1'b0;
    w0 = wlog_a.size();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = b2[i]; cyc(1);
      bus.in_valid = 1'b0; cyc(1);
    end
    chk("bp_wr_count", 32'(wlog_a.size() - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (wlog_a.size() > w0 + i) begin
        chk("bp_wr_addr", 32'(wlog_a[w0 + i]), 32'(i));
        chk("bp_wr_data", 32'(wlog_d[w0 + i]), 32'(b2[i]));
      end
    end
    wait_start_low(n);
    cyc(2);
    DONE = 1'b0;
    chk("done_first_dump", 32'(bus.out_valid), 32'd1);
    chk("done_first_rc",   32'(run_cycles),    32'd2);
    r0 = rd_pulses;
    for (int i = 0; i < 3; i++) begin chk("stall_hold", 32'(bus.out_data), 32'hA0); cyc(1); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin got[i] = bus.out_data; cyc(1); end
    bus.out_ready = 1'b0;
    chk("wrap_dump0", 32'(got[0]), 32'hA0);
    chk("wrap_dump1", 32'(got[1]), 32'hA1);
    chk("wrap_dump2", 32'(got[2]), 32'hA2);
    chk("wrap_dump3", 32'(got[3]), 32'hA3);
    cyc(2);
    chk("wrap_rd_pulses", 32'(rd_pulses - r0), 32'd1);

    // Run 3: DONE never arrives, timeout forces the dump
    go = 1'b1; cyc(1); go = 1'b0;
    for (int i = 0; i < 4; i++) begin bus.in_valid = 1'b1; bus.in_data = b1[i]; cyc(1); end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin n++; cyc(1); end
    chk("to_dump_reached", 32'(bus.out_valid), 32'd1);
    chk("to_flag",         32'(timed_out),     32'd1);
    chk("to_run_cycles",   32'(run_cycles),    32'd50);
    bus.out_ready = 1'b1; cyc(4); bus.out_ready = 1'b0;
    chk("to_idle",   32'(busy),      32'd0);
    chk("to_sticky", 32'(timed_out), 32'd1);
    cyc(1);

    // Run 4: go clears timeout status; reset lands in RUN cycle 10
    go = 1'b1; cyc(1); go = 1'b0;
    chk("go_clears_to", 32'(timed_out),  32'd0);
    chk("go_clears_rc", 32'(run_cycles), 32'd0);
    for (int i = 0; i < 4; i++) begin bus.in_valid = 1'b1; bus.in_data = b1[i]; cyc(1); end
    bus.in_valid = 1'b0;
    wait_start_low(n);
    cyc(9);
    chk("mid_in_run", 32'(START), 32'd0);
    reset = 1'b0; cyc(1); reset = 1'b1;
    chk("mid_rst_START",   32'(START),       32'd1);
    chk("mid_rst_mem_sel", 32'(bus.mem_sel), 32'd1);
    chk("mid_rst_busy",    32'(busy),        32'd0);
    chk("mid_rst_rc",      32'(run_cycles),  32'd0);
    cyc(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
